// File: rtl/stb_dcache_arbiter.sv
// ============================================================================
// Module   : stb_dcache_arbiter
// Purpose  : Shares one dcache port between the store-buffer drain and LSU loads.
//            Stores always drain ahead of loads, and a dcache ack that never
//            arrives raises a sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stb_dcache_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_empty,
    output logic                      dcache2stb_ack,
    input  logic [ADDR_WIDTH-1:0]     lsudbus2arb_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] lsudbus2arb_sel_byte,
    input  logic                      lsudbus2arb_req,
    output logic [DATA_WIDTH-1:0]     arb2lsudbus_rdata,
    output logic                      arb2lsudbus_ack,
    output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
    output logic                      arb2dcache_w_en,
    output logic                      arb2dcache_req,
    input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
    input  logic                      dcache2arb_ack,
    output logic                      arb_timeout_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_STB_XFER = 2'd1;
    localparam logic [1:0] S_LD_XFER  = 2'd2;

    localparam int             CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    logic [1:0]                state_q,    state_d;
    logic [CNT_W-1:0]          cnt_q,      cnt_d;
    logic                      req_q,      req_d;
    logic                      w_en_q,     w_en_d;
    logic                      err_q,      err_d;
    logic [ADDR_WIDTH-1:0]     addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
    logic [BYTE_SEL_WIDTH-1:0] sel_byte_q, sel_byte_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            w_en_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_byte_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            w_en_q     <= w_en_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_byte_q <= sel_byte_d;
        end
    end

    // Loads wait for an empty store buffer so they never bypass pending stores.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (stb2dcache_req) begin
                    state_d = S_STB_XFER;
                end else if (lsudbus2arb_req && stb2dcache_empty) begin
                    state_d = S_LD_XFER;
                end
            end
            S_STB_XFER, S_LD_XFER: begin
                if (dcache2arb_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        req_d      = req_q;
        w_en_d     = w_en_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_byte_d = sel_byte_q;
        if (state_q == S_IDLE) begin
            if (state_d == S_STB_XFER) begin
                req_d      = 1'b1;
                cnt_d      = '0;
                addr_d     = stb2dcache_addr;
                wdata_d    = stb2dcache_wdata;
                sel_byte_d = stb2dcache_sel_byte;
                w_en_d     = stb2dcache_w_en;
            end else if (state_d == S_LD_XFER) begin
                req_d      = 1'b1;
                cnt_d      = '0;
                addr_d     = lsudbus2arb_addr;
                wdata_d    = '0;
                sel_byte_d = lsudbus2arb_sel_byte;
                w_en_d     = 1'b0;
            end
        end else if (dcache2arb_ack) begin
            req_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            // Saturating wait counter; the transfer keeps waiting past the limit.
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        dcache2stb_ack    = dcache2arb_ack & (state_q == S_STB_XFER);
        arb2lsudbus_ack   = dcache2arb_ack & (state_q == S_LD_XFER);
        arb2lsudbus_rdata = (state_q == S_LD_XFER) ? dcache2arb_rdata : '0;
    end

    assign arb2dcache_addr     = addr_q;
    assign arb2dcache_wdata    = wdata_q;
    assign arb2dcache_sel_byte = sel_byte_q;
    assign arb2dcache_w_en     = w_en_q;
    assign arb2dcache_req      = req_q;
    assign arb_timeout_err     = err_q;

endmodule

`default_nettype wire

// File: doc/stb_dcache_arbiter.md
Name: stb_dcache_arbiter

Overview:
- Sits directly downstream of store_buffer_top, between the store-buffer drain port, the LSU load path and the single dcache port.
- Grants the dcache port to one requester at a time and holds the request stable until the dcache acks.
- Enforces store-before-load ordering: a load is issued only when the store buffer is empty.
- Flags dcache acks that never arrive with a sticky timeout error.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BYTE_SEL_WIDTH, 4, byte-select width
ACK_TIMEOUT, 64, cycles waited for dcache ack before timeout error is flagged (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
stb2dcache_addr  in  ADDR_WIDTH  store address from store buffer
stb2dcache_wdata  in  DATA_WIDTH  store data
stb2dcache_sel_byte  in  BYTE_SEL_WIDTH  store byte enables
stb2dcache_w_en  in  1  store write enable
stb2dcache_req  in  1  store request, held until dcache2stb_ack
stb2dcache_empty  in  1  store buffer empty
dcache2stb_ack  out  1  store completion pulse to store buffer
lsudbus2arb_addr  in  ADDR_WIDTH  load address
lsudbus2arb_sel_byte  in  BYTE_SEL_WIDTH  load byte enables
lsudbus2arb_req  in  1  load request, held until arb2lsudbus_ack
arb2lsudbus_rdata  out  DATA_WIDTH  load data
arb2lsudbus_ack  out  1  load completion pulse
arb2dcache_addr  out  ADDR_WIDTH  dcache address
arb2dcache_wdata  out  DATA_WIDTH  dcache write data
arb2dcache_sel_byte  out  BYTE_SEL_WIDTH  dcache byte enables
arb2dcache_w_en  out  1  1 = write, 0 = read
arb2dcache_req  out  1  dcache request
dcache2arb_rdata  in  DATA_WIDTH  dcache read data
dcache2arb_ack  in  1  dcache completion pulse
arb_timeout_err  out  1  sticky ack-timeout flag

Behaviour:
- FSM states: IDLE, STB_XFER, LD_XFER. On reset: state IDLE, timeout counter 0, all registered outputs 0 (arb2dcache_req/addr/wdata/sel_byte/w_en, arb_timeout_err). dcache2stb_ack, arb2lsudbus_ack and arb2lsudbus_rdata are forced to 0 while in IDLE.
- IDLE -> STB_XFER when stb2dcache_req=1. Priority over loads.
- IDLE -> LD_XFER when lsudbus2arb_req=1, stb2dcache_req=0 and stb2dcache_empty=1.
- Load pending with stb2dcache_empty=0 and stb2dcache_req=0: stay IDLE; the load waits.
- On the grant edge, register the requester's addr/data/sel_byte and set arb2dcache_req=1.
  - Store: arb2dcache_w_en=stb2dcache_w_en.
  - Load: arb2dcache_w_en=0, arb2dcache_wdata=0.
- Latency: request sampled in IDLE at edge N gives arb2dcache_req=1 after edge N (one-cycle issue latency).
- In XFER the dcache outputs stay stable until ack; input changes from the requester are ignored.
- Responses are combinational pass-through, no added latency:
  - dcache2stb_ack = dcache2arb_ack & (state==STB_XFER)
  - arb2lsudbus_ack = dcache2arb_ack & (state==LD_XFER)
  - arb2lsudbus_rdata = dcache2arb_rdata when in LD_XFER, else 0
- On the ack cycle: next state IDLE and arb2dcache_req=0 after the edge. There is a minimum one-cycle bubble between back-to-back transactions.
- dcache2arb_ack in IDLE is ignored and produces no pulse.
- Timeout counter:
  - Cleared on entry to XFER; increments each XFER cycle without ack; saturates at ACK_TIMEOUT.
  - Reaching ACK_TIMEOUT sets arb_timeout_err. It clears only on rst.
  - The transaction is not abandoned: the block keeps waiting for ack.
- Reset mid-transaction: asynchronous return to IDLE, arb2dcache_req drops immediately and the in-flight transfer is discarded. Requesters are reset by the same rst.
- Simultaneous store and load requests in IDLE with buffer non-empty: the store is granted. The load is granted after the buffer reports empty.

Test Plan:
- Reset: assert rst mid STB_XFER -> arb2dcache_req=0 and arb_timeout_err=0 immediately. After release, IDLE with no acks.
- Single store: stb req addr=0x10, wdata=0xDEADBEEF, sel=0xF, w_en=1 at edge N -> arb2dcache_req=1 with those values after N. dcache ack 2 cycles later -> dcache2stb_ack high in the same cycle, req low next cycle.
- Ordering: stb_empty=0, stb_req=1 and load req addr=0x20 together -> store issued first. The load is not issued until stb_empty=1, then arb2dcache_w_en=0, addr=0x20. rdata=0x12345678 returned with arb2lsudbus_ack on the ack cycle.
- Load blocked: lsu req with stb_empty=0, stb_req=0 for 5 cycles -> arb2dcache_req stays 0. Deassert empty-block -> load issued the next cycle.
- Back-to-back stores: 4 stores with immediate acks -> each issued one cycle after the prior ack cycle, with a one-cycle bubble between. Data order preserved, 4 dcache2stb_ack pulses.
- Timeout: ACK_TIMEOUT=8, withhold ack -> arb_timeout_err rises after 8 XFER cycles with the request still held. A late ack completes the transfer and the error stays 1.
